pac_sprite_plotter: RTL
=======================

# pac_sprite_plotter

Rasterises one 5x5 sprite bitmap from the Pac-Man sprite shifter into single-pixel writes for the VGA framebuffer adapter. Sits directly downstream of the sprite shifter and upstream of the VGA adapter's plot port. On each start pulse it draws the bitmap at a given position, one pixel per clock, then pulses done. The game controller uses the same block to erase, by presenting an all-zero bitmap.

## Interface
- SPRITE_W, 5, sprite width in pixels
- SPRITE_H, 5, sprite height in pixels
- BG_COLOUR, 3'b000, colour written for 0 bits

- clock  in  1  system clock; all logic on posedge
- resetn  in  1  synchronous, active-low reset
- start  in  1  draw request; sampled only in IDLE
- x_in  in  8  sprite top-left x, latched on accepted start
- y_in  in  7  sprite top-left y, latched on accepted start
- bitmap  in  25  sprite pixels; bit 24 is top-left, row-major, bit 0 is bottom-right
- colour_in  in  3  foreground colour for 1 bits, latched on start
- x_out  out  8  pixel x to adapter
- y_out  out  7  pixel y to adapter
- colour_out  out  3  pixel colour to adapter
- plot  out  1  write strobe to adapter, one pixel per high cycle
- busy  out  1  high while a draw is in progress
- done  out  1  one-cycle pulse after the last pixel

## Operation
- States: IDLE, DRAW, DONE.
- IDLE -> DRAW on start=1.
  - Latch x_in, y_in, bitmap and colour_in.
  - Clear row and col to 0.
- DRAW: each cycle registers one pixel and advances col.
  - Pixel output: x_out = x_base + col, y_out = y_base + row.
  - colour_out = colour_lat when bitmap_lat[24 - (row*5 + col)] is 1, else BG_COLOUR.
  - plot = 1.
  - When col = SPRITE_W-1, col wraps to 0 and row increments.
  - After pixel (row 4, col 4), DRAW -> DONE.
- DONE: done=1 and plot=0 for one cycle, then -> IDLE.
- busy = 1 in DRAW and DONE, 0 in IDLE.
- start is ignored in DRAW and DONE. No queuing.
- Input changes after the start is accepted have no effect on a draw in progress.
- Coordinate arithmetic:
  - x is 8-bit unsigned, modulo 256.
  - y is 7-bit unsigned, modulo 128.
  - No clipping; the controller keeps sprites on screen.
- Reset values: all outputs 0, state IDLE. Internal latches and counters are cleared.
- Reset mid-draw:
  - State returns to IDLE on that edge.
  - plot drops the following cycle, and no further pixels are emitted.
  - done is not pulsed.
- Reset has priority over start when both are asserted in the same cycle.

## Timing
- Cycle 0: start=1 sampled while in IDLE.
- Cycles 1..25: plot=1, one pixel per cycle in row-major order. Cycle 1 emits (x_in, y_in).
- Cycle 26: done=1, plot=0.
- Cycle 27: IDLE. A start in cycle 27 is accepted.
- Throughput: one sprite per 27 cycles when start is held high.
- busy is high in cycles 1..26.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- PAC_PLOTTER_TRANSPARENT_EN
  - Defined: 0 bits produce plot=0 in their slot. Background pixels are left untouched, colour_out = BG_COLOUR, and x_out/y_out still advance.
  - Not defined: every one of the 25 slots plots; 0 bits are written as BG_COLOUR.
- Latency is 27 cycles in both configurations.

## Structure
- Shared package pac_pkg holds:
  - SPRITE_W, SPRITE_H and SPRITE_BITS (25).
  - Colour constants COL_BLACK and COL_YELLOW.
  - The plotter state enum.
- One sub-module: pac_pixel_counter.
  - col/row counter with a col wrap into row, clear and enable inputs, and a last flag at (4,4).
  - Instantiated once.

## Test plan
- Reset, then idle for 5 cycles -> plot, busy, done, x_out, y_out and colour_out all stay 0.
- start with x_in=10, y_in=20, bitmap=25'b0111011111110001111101110, colour_in=3'b110 ->
  - Cycles 1..25 emit (10..14, 20..24) row-major.
  - Cycle 1 colour=000, cycle 2 colour=110.
  - done pulses at cycle 26; exactly 25 plots.
- Same draw built with PAC_PLOTTER_TRANSPARENT_EN defined -> exactly 18 plot cycles, one per 1 bit, at the matching coordinates; done still at cycle 26.
- start with x_in=254, y_in=126, bitmap all ones -> x_out sequence 254,255,0,1,2 and y_out wraps 126,127,0,1,2.
- start re-pulsed at cycles 5 and 26, with x_in changed to 99 at cycle 5 -> both pulses ignored; all pixels use the originally latched x.
- resetn=0 at cycle 12 of a draw -> from cycle 13 on, plot=0, busy=0 and done is never asserted; a new start at cycle 14 draws all 25 pixels normally.

Source files
------------

// File: rtl/pac_pkg.sv
// pac_pkg: shared sprite geometry, colour constants and plotter state encoding
package pac_pkg;
  localparam int SPRITE_W = 5;
  localparam int SPRITE_H = 5;
  localparam int SPRITE_BITS = SPRITE_W * SPRITE_H;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} plot_state_t;
  function automatic logic [4:0] pixel_idx(input logic [2:0] row, input logic [2:0] col);
    return 5'(SPRITE_BITS - 1 - (int'(row) * SPRITE_W + int'(col)));
  endfunction
endpackage

// File: rtl/pac_pixel_counter.sv
// pac_pixel_counter: col/row raster counter over the sprite, col wraps into row
module pac_pixel_counter
  import pac_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] next_col,
  output logic [2:0] next_row,
  output logic       last
);
  logic [2:0] col, row;
  logic col_end;
  always_comb begin
    col_end = col == 3'(SPRITE_W - 1);
    next_col = col_end ? 3'd0 : col + 3'd1;
    next_row = col_end ? row + 3'd1 : row;
    last = col_end && row == 3'(SPRITE_H - 1);
  end
  always_ff @(posedge clock)
    if (!resetn || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      col <= next_col;
      row <= next_row;
    end
endmodule

// File: rtl/pac_sprite_plotter.sv
// pac_sprite_plotter: rasterises a 5x5 sprite into one registered pixel write per clock.
// Define PAC_PLOTTER_TRANSPARENT_EN to suppress plot on 0 bits (background left untouched).
module pac_sprite_plotter
  import pac_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR = COL_BLACK
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [24:0] bitmap,
  input  logic [2:0]  colour_in,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        plot,
  output logic        busy,
  output logic        done
);
  plot_state_t state;
  logic [7:0] x_base;
  logic [6:0] y_base;
  logic [24:0] bitmap_lat;
  logic [2:0] colour_lat, next_col, next_row;
  logic last, clear, enable, first_bit, next_bit, first_plot, next_plot;
  // The counter tracks the pixel already on the outputs; the accepting edge emits pixel (0,0) directly.
  assign clear = state == S_IDLE && start;
  assign enable = state == S_DRAW && !last;
  assign first_bit = bitmap[SPRITE_BITS - 1];
  assign next_bit = bitmap_lat[pixel_idx(next_row, next_col)];
`ifdef PAC_PLOTTER_TRANSPARENT_EN
  assign first_plot = first_bit;
  assign next_plot = next_bit;
`else
  assign first_plot = 1'b1;
  assign next_plot = 1'b1;
`endif
  pac_pixel_counter u_counter (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .enable   (enable),
    .next_col (next_col),
    .next_row (next_row),
    .last     (last)
  );
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= S_IDLE;
      x_base <= '0;
      y_base <= '0;
      bitmap_lat <= '0;
      colour_lat <= '0;
      x_out <= '0;
      y_out <= '0;
      colour_out <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_DRAW;
          x_base <= x_in;
          y_base <= y_in;
          bitmap_lat <= bitmap;
          colour_lat <= colour_in;
          x_out <= x_in;
          y_out <= y_in;
          colour_out <= first_bit ? colour_in : BG_COLOUR;
          plot <= first_plot;
          busy <= 1'b1;
        end
        S_DRAW: if (last) begin
          state <= S_DONE;
          plot <= 1'b0;
          done <= 1'b1;
        end else begin
          x_out <= x_base + 8'(next_col);
          y_out <= y_base + 7'(next_row);
          colour_out <= next_bit ? colour_lat : BG_COLOUR;
          plot <= next_plot;
        end
        default: begin
          state <= S_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
